// File: rtl/amns_operand_sequencer.sv
// Control sequencer between the bridge BRAM and the AMNS operand/result registers:
// loads M'0, M, A, B, kicks FIOS, writes the result back. Optional build macro: AMNS_MOD_CACHE_EN.
module amns_operand_sequencer #(
  parameter int s      = 4,
  parameter int N      = 5,
  parameter int RD_LAT = 2,
  parameter int ADDR_W = $clog2(4*N*s)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
`ifdef AMNS_MOD_CACHE_EN
  input  logic              reload_mod_i,
`endif
  input  logic              FIOS_done_i,
  output logic              M_prime_0_reg_en_o,
  output logic              M_reg_en_o,
  output logic              A_reg_en_o,
  output logic              B_reg_en_o,
  output logic              FIOS_start_o,
  output logic              BRAM_we_o,
  output logic [ADDR_W-1:0] BRAM_addr_o,
  output logic              BRAM_en_o,
  output logic              done_o,
  output logic              busy_o
);

  localparam int NS      = N * s;
  localparam int CNT_MAX = (NS > RD_LAT) ? NS : RD_LAT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]  LAST_MP0   = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0]  LAST_NS    = CNT_W'(NS - 1);
  localparam logic [CNT_W-1:0]  LAST_DRAIN = CNT_W'(RD_LAT - 1);

  localparam logic [ADDR_W-1:0] BASE_M = ADDR_W'(NS);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(2 * NS);
  localparam logic [ADDR_W-1:0] BASE_B = ADDR_W'(3 * NS);

  localparam logic [1:0] TAG_MP0 = 2'd0;
  localparam logic [1:0] TAG_M   = 2'd1;
  localparam logic [1:0] TAG_A   = 2'd2;
  localparam logic [1:0] TAG_B   = 2'd3;

  typedef enum logic [3:0] {
    IDLE,
    LD_MP0,
    LD_M,
    LD_A,
    LD_B,
    DRAIN,
    START,
    WAIT,
    STORE,
    DONE
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_n;

  logic [ADDR_W-1:0]  addr_n;
  logic               en_n;
  logic               we_n;
  logic               fstart_n;
  logic               done_n;
  logic               busy_n;
  logic               vld_n;
  logic [1:0]         tag_n;

  logic               vld_p [RD_LAT];
  logic [1:0]         tag_p [RD_LAT];

`ifdef AMNS_MOD_CACHE_EN
  logic               mod_valid;
`endif

  // Next-state and next-output decode; every output is registered from these.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;

    case (state)
      IDLE: begin
        if (start_i) begin
          cnt_n = '0;
`ifdef AMNS_MOD_CACHE_EN
          state_n = (mod_valid && !reload_mod_i) ? LD_A : LD_MP0;
`else
          state_n = LD_MP0;
`endif
        end
      end
      LD_MP0: begin
        if (cnt == LAST_MP0) begin
          state_n = LD_M;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      LD_M: begin
        if (cnt == LAST_NS) begin
          state_n = LD_A;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      LD_A: begin
        if (cnt == LAST_NS) begin
          state_n = LD_B;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      LD_B: begin
        if (cnt == LAST_NS) begin
          state_n = DRAIN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == LAST_DRAIN) begin
          state_n = START;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      START: begin
        state_n = WAIT;
      end
      WAIT: begin
        if (FIOS_done_i) begin
          state_n = STORE;
          cnt_n   = '0;
        end
      end
      STORE: begin
        if (cnt == LAST_NS) begin
          state_n = DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    addr_n   = '0;
    en_n     = 1'b0;
    we_n     = 1'b0;
    fstart_n = 1'b0;
    done_n   = 1'b0;
    vld_n    = 1'b0;
    tag_n    = TAG_MP0;
    busy_n   = (state_n != IDLE);

    case (state_n)
      LD_MP0: begin
        en_n   = 1'b1;
        vld_n  = 1'b1;
        tag_n  = TAG_MP0;
        addr_n = ADDR_W'(cnt_n);
      end
      LD_M: begin
        en_n   = 1'b1;
        vld_n  = 1'b1;
        tag_n  = TAG_M;
        addr_n = BASE_M + ADDR_W'(cnt_n);
      end
      LD_A: begin
        en_n   = 1'b1;
        vld_n  = 1'b1;
        tag_n  = TAG_A;
        addr_n = BASE_A + ADDR_W'(cnt_n);
      end
      LD_B: begin
        en_n   = 1'b1;
        vld_n  = 1'b1;
        tag_n  = TAG_B;
        addr_n = BASE_B + ADDR_W'(cnt_n);
      end
      START: fstart_n = 1'b1;
      STORE: begin
        en_n   = 1'b1;
        we_n   = 1'b1;
        addr_n = ADDR_W'(cnt_n);
      end
      DONE: done_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state              <= IDLE;
      cnt                <= '0;
      BRAM_addr_o        <= '0;
      BRAM_en_o          <= 1'b0;
      BRAM_we_o          <= 1'b0;
      FIOS_start_o       <= 1'b0;
      done_o             <= 1'b0;
      busy_o             <= 1'b0;
      M_prime_0_reg_en_o <= 1'b0;
      M_reg_en_o         <= 1'b0;
      A_reg_en_o         <= 1'b0;
      B_reg_en_o         <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        vld_p[i] <= 1'b0;
        tag_p[i] <= TAG_MP0;
      end
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      BRAM_addr_o  <= addr_n;
      BRAM_en_o    <= en_n;
      BRAM_we_o    <= we_n;
      FIOS_start_o <= fstart_n;
      done_o       <= done_n;
      busy_o       <= busy_n;

      // Stage 0 travels with the issued address; stage k lags it by k cycles.
      vld_p[0] <= vld_n;
      tag_p[0] <= tag_n;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        tag_p[i] <= tag_p[i-1];
      end

      // Final register lands the enable RD_LAT cycles after its address.
      M_prime_0_reg_en_o <= vld_p[RD_LAT-1] && (tag_p[RD_LAT-1] == TAG_MP0);
      M_reg_en_o         <= vld_p[RD_LAT-1] && (tag_p[RD_LAT-1] == TAG_M);
      A_reg_en_o         <= vld_p[RD_LAT-1] && (tag_p[RD_LAT-1] == TAG_A);
      B_reg_en_o         <= vld_p[RD_LAT-1] && (tag_p[RD_LAT-1] == TAG_B);
    end
  end

`ifdef AMNS_MOD_CACHE_EN
  // Modulus words stay resident in M'0/M once a full LD_M has completed.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      mod_valid <= 1'b0;
    end else if (state == LD_M && cnt == LAST_NS) begin
      mod_valid <= 1'b1;
    end
  end
`endif

  enable_onehot: assert property (@(posedge clock_i) disable iff (!reset_i)
    $onehot0({M_prime_0_reg_en_o, M_reg_en_o, A_reg_en_o, B_reg_en_o}));

  addr_in_range: assert property (@(posedge clock_i) disable iff (!reset_i)
    BRAM_addr_o <= ADDR_W'(4 * NS - 1));

endmodule

// File: tb/tb_amns_operand_sequencer.sv
// Directed bench for amns_operand_sequencer (s=4, N=5, RD_LAT=2): vector table plus
// cycle-indexed model sweeps of whole runs, back-to-back, ignored inputs and async reset.
module tb_amns_operand_sequencer;

  localparam int S      = 4;
  localparam int N      = 5;
  localparam int RD_LAT = 2;
  localparam int NS     = N * S;
  localparam int AW     = 7;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          start_i;
  logic          FIOS_done_i;
  logic          M_prime_0_reg_en_o;
  logic          M_reg_en_o;
  logic          A_reg_en_o;
  logic          B_reg_en_o;
  logic          FIOS_start_o;
  logic          BRAM_we_o;
  logic [AW-1:0] BRAM_addr_o;
  logic          BRAM_en_o;
  logic          done_o;
  logic          busy_o;
`ifdef AMNS_MOD_CACHE_EN
  logic          reload_mod_i;
`endif

  amns_operand_sequencer #(.s(S), .N(N), .RD_LAT(RD_LAT), .ADDR_W(AW)) dut (
    .clock_i            (clock_i),
    .reset_i            (reset_i),
    .start_i            (start_i),
`ifdef AMNS_MOD_CACHE_EN
    .reload_mod_i       (reload_mod_i),
`endif
    .FIOS_done_i        (FIOS_done_i),
    .M_prime_0_reg_en_o (M_prime_0_reg_en_o),
    .M_reg_en_o         (M_reg_en_o),
    .A_reg_en_o         (A_reg_en_o),
    .B_reg_en_o         (B_reg_en_o),
    .FIOS_start_o       (FIOS_start_o),
    .BRAM_we_o          (BRAM_we_o),
    .BRAM_addr_o        (BRAM_addr_o),
    .BRAM_en_o          (BRAM_en_o),
    .done_o             (done_o),
    .busy_o             (busy_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic en;
    logic we;
    logic mp;
    logic m;
    logic a;
    logic b;
    logic fs;
    logic dn;
    logic busy;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t exp;
  } vec_t;

  obs_t trace [0:1023];
  vec_t vecs  [0:31];
  int   nv;
  int   errors;
  int   checks;
  int   done_cnt;

  function automatic obs_t mk(input int addr, input bit en, input bit we, input bit mp,
                              input bit m, input bit a, input bit b, input bit fs,
                              input bit dn, input bit busy);
    obs_t o;
    o.addr = AW'(addr);
    o.en = en; o.we = we; o.mp = mp; o.m = m; o.a = a; o.b = b;
    o.fs = fs; o.dn = dn; o.busy = busy;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.addr = BRAM_addr_o;
    o.en = BRAM_en_o; o.we = BRAM_we_o;
    o.mp = M_prime_0_reg_en_o; o.m = M_reg_en_o; o.a = A_reg_en_o; o.b = B_reg_en_o;
    o.fs = FIOS_start_o; o.dn = done_o; o.busy = busy_o;
    return o;
  endfunction

  // The address is only meaningful while the BRAM is enabled.
  function automatic obs_t mask(input obs_t o);
    obs_t r;
    r = o;
    if (!r.en) r.addr = '0;
    return r;
  endfunction

  function automatic int issue_addr(input int i, input bit skip);
    if (skip) return 2 * NS + i;
    if (i < N) return i;
    return NS + (i - N);
  endfunction

  function automatic int issue_tag(input int i, input bit skip);
    if (skip) return (i < NS) ? 2 : 3;
    if (i < N) return 0;
    if (i < N + NS) return 1;
    if (i < N + 2 * NS) return 2;
    return 3;
  endfunction

  // Expected outputs in cycle c of a run (cycle 1 follows the start edge),
  // with FIOS_done_i driven high during cycle w.
  function automatic obs_t model(input int c, input int w, input bit skip);
    obs_t o;
    int   ld;
    o  = '0;
    ld = skip ? 2 * NS : N + 3 * NS;
    o.busy = (c >= 1) && (c <= w + NS + 1);
    if (c >= 1 && c <= ld) begin
      o.en   = 1'b1;
      o.addr = AW'(issue_addr(c - 1, skip));
    end
    if (c >= RD_LAT + 1 && c <= ld + RD_LAT) begin
      case (issue_tag(c - RD_LAT - 1, skip))
        0:       o.mp = 1'b1;
        1:       o.m  = 1'b1;
        2:       o.a  = 1'b1;
        default: o.b  = 1'b1;
      endcase
    end
    o.fs = (c == ld + RD_LAT + 1);
    if (c >= w + 1 && c <= w + NS) begin
      o.en   = 1'b1;
      o.we   = 1'b1;
      o.addr = AW'(c - w - 1);
    end
    o.dn = (c == w + NS + 1);
    return o;
  endfunction

  task automatic check(input string name, input int c, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got addr=%0d en,we,mp,m,a,b,fs,dn,busy=%b want addr=%0d en,we,mp,m,a,b,fs,dn,busy=%b",
               name, c, act.addr, act[8:0], exp.addr, exp[8:0]);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    @(negedge clock_i);
  endtask

  task automatic add_vec(input int cyc, input obs_t e);
    vecs[nv].cyc = cyc;
    vecs[nv].exp = e;
    nv++;
  endtask

  // One run: cycle 0 is the IDLE cycle in which start_i is raised; capture ends in cycle len.
  task automatic run(input int w, input int len, input bit hold, input int glitch);
    step();
    trace[0] = sample();
    start_i  = 1'b1;
    for (int c = 1; c <= len; c++) begin
      step();
      trace[c]    = sample();
      start_i     = hold && (c < len);
      FIOS_done_i = (c == w) || (c == glitch);
      if (trace[c].dn) done_cnt++;
    end
    start_i     = 1'b0;
    FIOS_done_i = 1'b0;
  endtask

  task automatic check_trace(input string name, input int len, input int w, input bit skip);
    for (int c = 0; c <= len; c++) check(name, c, mask(trace[c]), mask(model(c, w, skip)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0; checks = 0; nv = 0; done_cnt = 0;
    reset_i = 1'b0; start_i = 1'b0; FIOS_done_i = 1'b0;
`ifdef AMNS_MOD_CACHE_EN
    reload_mod_i = 1'b1;
`endif

    // Hand-computed checkpoints of a full run with FIOS_done_i high in cycle 569.
    add_vec(0,   mk(0,  0,0,0,0,0,0,0,0,0));
    add_vec(1,   mk(0,  1,0,0,0,0,0,0,0,1));
    add_vec(3,   mk(2,  1,0,1,0,0,0,0,0,1));
    add_vec(5,   mk(4,  1,0,1,0,0,0,0,0,1));
    add_vec(6,   mk(20, 1,0,1,0,0,0,0,0,1));
    add_vec(7,   mk(21, 1,0,1,0,0,0,0,0,1));
    add_vec(8,   mk(22, 1,0,0,1,0,0,0,0,1));
    add_vec(26,  mk(40, 1,0,0,1,0,0,0,0,1));
    add_vec(28,  mk(42, 1,0,0,0,1,0,0,0,1));
    add_vec(46,  mk(60, 1,0,0,0,1,0,0,0,1));
    add_vec(48,  mk(62, 1,0,0,0,0,1,0,0,1));
    add_vec(65,  mk(79, 1,0,0,0,0,1,0,0,1));
    add_vec(66,  mk(0,  0,0,0,0,0,1,0,0,1));
    add_vec(67,  mk(0,  0,0,0,0,0,1,0,0,1));
    add_vec(68,  mk(0,  0,0,0,0,0,0,1,0,1));
    add_vec(69,  mk(0,  0,0,0,0,0,0,0,0,1));
    add_vec(569, mk(0,  0,0,0,0,0,0,0,0,1));
    add_vec(570, mk(0,  1,1,0,0,0,0,0,0,1));
    add_vec(589, mk(19, 1,1,0,0,0,0,0,0,1));
    add_vec(590, mk(0,  0,0,0,0,0,0,0,1,1));

    repeat (3) @(negedge clock_i);
    check("reset_state", 0, sample(), '0);
    reset_i = 1'b1;

    // Full run, FIOS_done_i held low for 500 WAIT cycles.
    run(569, 590, 1'b0, -1);
    for (int i = 0; i < nv; i++)
      check("vec", vecs[i].cyc, mask(trace[vecs[i].cyc]), mask(vecs[i].exp));
    check_trace("run1", 590, 569, 1'b0);

    // Second run with start_i in the cycle right after done_o.
    run(569, 590, 1'b0, -1);
    check_trace("run2", 590, 569, 1'b0);

    // start_i held high all run, stray FIOS_done_i during LD_A.
    done_cnt = 0;
    run(75, 96, 1'b1, 30);
    check_trace("held", 96, 75, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("held_idle", 97 + i, mask(sample()), '0);
      if (done_o) done_cnt++;
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL held_done_count got=%0d want=1", done_cnt);
    end

    // Asynchronous reset in the 10th STORE cycle.
    run(75, 84, 1'b0, -1);
    check_trace("pre_rst", 84, 75, 1'b0);
    step();
    check("store_c10", 85, mask(sample()), mask(model(85, 75, 1'b0)));
    #2 reset_i = 1'b0;
    #1 check("rst_async", 85, sample(), '0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock_i);
      check("rst_hold", i, sample(), '0);
    end
    reset_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("post_rst", i, mask(sample()), '0);
    end

`ifdef AMNS_MOD_CACHE_EN
    reload_mod_i = 1'b0;
    run(75, 96, 1'b0, -1);
    check_trace("cache_cold", 96, 75, 1'b0);
    run(50, 71, 1'b0, -1);
    check_trace("cache_hit", 71, 50, 1'b1);
    reload_mod_i = 1'b1;
    run(75, 96, 1'b0, -1);
    check_trace("cache_reload", 96, 75, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
